// File: rtl/arp_pkg.sv
// Shared types and constants for the ARP cache controller and its CAM.
package arp_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEARCH    = 3'd1,
        TX_REQ    = 3'd2,
        WAIT_TXD  = 3'd3,
        WAIT_RPL  = 3'd4,
        TX_RPL    = 3'd5,
        WAIT_RPLD = 3'd6,
        DONE      = 3'd7
    } arp_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] ip;
        logic [47:0] mac;
    } arp_entry_t;

    localparam logic        ARP_OP_REQ    = 1'b0;
    localparam logic        ARP_OP_RPL    = 1'b1;
    localparam logic [47:0] ARP_BCAST_MAC = 48'hffff_ffff_ffff;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arp_cam.sv
// IP->MAC table: parallel search, learn with update/free-slot/round-robin victim.
// Per-entry aging is built only when ARP_CACHE_AGING_EN is defined.
module arp_cam
    import arp_pkg::*;
#(
    parameter int unsigned ENTRIES = 4,
    parameter logic [31:0] AGE_CYC = 32'd3_750_000_000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        learn_i,
    input  logic [31:0]                 learn_ip_i,
    input  logic [47:0]                 learn_mac_i,
    input  logic [31:0]                 search_ip_i,
    output logic                        hit_o,
    output logic [idx_w(ENTRIES)-1:0]   idx_o,
    output logic [47:0]                 mac_o
);
    localparam int IW = idx_w(ENTRIES);

    arp_entry_t         tbl_q [ENTRIES];
    logic [IW-1:0]      victim_q;
    logic [ENTRIES-1:0] expire;

    logic               srch_hit, lrn_hit, free_hit, use_victim, byp;
    logic [IW-1:0]      srch_idx, lrn_idx, free_idx, wr_idx;

    always_comb begin
        srch_hit = 1'b0;
        srch_idx = '0;
        lrn_hit  = 1'b0;
        lrn_idx  = '0;
        free_hit = 1'b0;
        free_idx = '0;
        // Descending scan so the lowest matching index wins.
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (tbl_q[i].valid && (tbl_q[i].ip == search_ip_i)) begin
                srch_hit = 1'b1;
                srch_idx = IW'(i);
            end
            if (tbl_q[i].valid && (tbl_q[i].ip == learn_ip_i)) begin
                lrn_hit = 1'b1;
                lrn_idx = IW'(i);
            end
            if (!tbl_q[i].valid) begin
                free_hit = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    assign use_victim = !lrn_hit && !free_hit;
    assign wr_idx     = lrn_hit ? lrn_idx : (free_hit ? free_idx : victim_q);

    // A learn of the searched IP in the same cycle is forwarded as a hit.
    assign byp   = learn_i && !clr_i && (learn_ip_i == search_ip_i);
    assign hit_o = byp || srch_hit;
    assign idx_o = byp ? wr_idx : srch_idx;
    assign mac_o = byp ? learn_mac_i : tbl_q[srch_idx].mac;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= '0;
            victim_q <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < ENTRIES; i++) tbl_q[i].valid <= 1'b0;
            victim_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (expire[i]) tbl_q[i].valid <= 1'b0;
            end
            if (learn_i) begin
                tbl_q[wr_idx] <= '{valid: 1'b1, ip: learn_ip_i, mac: learn_mac_i};
                if (use_victim) begin
                    victim_q <= (victim_q == IW'(ENTRIES - 1)) ? '0 : victim_q + 1'b1;
                end
            end
        end
    end

`ifdef ARP_CACHE_AGING_EN
    localparam int AW = (AGE_CYC > 32'd2) ? $clog2(AGE_CYC) : 1;
    localparam logic [AW-1:0] AGE_LAST = AW'(AGE_CYC - 32'd1);

    logic [AW-1:0] age_q [ENTRIES];

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            expire[i] = tbl_q[i].valid && (age_q[i] == AGE_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (clr_i || expire[i] || (learn_i && (wr_idx == IW'(i)))) begin
                    age_q[i] <= '0;
                end else if (tbl_q[i].valid) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end
`else
    assign expire = '0;
`endif

endmodule

// File: rtl/arp_cache_ctrl.sv
// ARP resolver: cached lookups, request/timeout/retry on miss, auto-reply to requests.
// Entry aging is enabled by defining ARP_CACHE_AGING_EN.
//
// state     | meaning
// IDLE      | nothing in progress; pending reply beats a lookup
// SEARCH    | compare lookup IP against the cache
// TX_REQ    | one-cycle broadcast ARP request trigger
// WAIT_TXD  | wait for request transmit completion
// WAIT_RPL  | reply timer running; retry or fail on expiry
// TX_RPL    | one-cycle ARP reply trigger to latched requester
// WAIT_RPLD | wait for reply transmit completion
// DONE      | one-cycle lookup result strobe
module arp_cache_ctrl
    import arp_pkg::*;
#(
    parameter int unsigned ENTRIES     = 4,
    parameter int unsigned TIMEOUT_CYC = 125_000_000,
    parameter int unsigned RETRY_MAX   = 3,
    parameter logic [31:0] AGE_CYC     = 32'd3_750_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lookup_req,
    input  logic [31:0] lookup_ip,
    output logic        lookup_busy,
    output logic        lookup_ack,
    output logic        lookup_hit,
    output logic [47:0] lookup_mac,
    input  logic        arp_rx_done,
    input  logic        arp_rx_type,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    output logic        arp_tx_en,
    output logic        arp_tx_type,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    input  logic        tx_done,
    input  logic        cache_clr
);
    localparam int IW = idx_w(ENTRIES);
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    ATT_MAX  = 4'(RETRY_MAX);

    arp_state_e    state_q, state_d;
    logic          lk_act_q, lk_got_q, res_hit_q, from_wait_q, rpl_pend_q, tx_type_q;
    logic [31:0]   lk_ip_q, rpl_ip_q, des_ip_q;
    logic [47:0]   res_mac_q, rpl_mac_q, des_mac_q;
    logic [3:0]    att_q;
    logic [TW-1:0] tmr_q;

    logic          cam_hit, lk_accept, rx_match, lk_got, tmr_run;
    logic [IW-1:0] cam_idx;
    logic [47:0]   cam_mac;

    arp_cam #(
        .ENTRIES (ENTRIES),
        .AGE_CYC (AGE_CYC)
    ) u_cam (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (cache_clr),
        .learn_i     (arp_rx_done),
        .learn_ip_i  (src_ip),
        .learn_mac_i (src_mac),
        .search_ip_i (lk_ip_q),
        .hit_o       (cam_hit),
        .idx_o       (cam_idx),
        .mac_o       (cam_mac)
    );

    assign lk_accept = lookup_req && !lk_act_q;
    assign rx_match  = arp_rx_done && (src_ip == lk_ip_q);
    assign lk_got    = lk_got_q || rx_match;
    assign tmr_run   = (state_q == WAIT_RPL) ||
                       (((state_q == TX_RPL) || (state_q == WAIT_RPLD)) && from_wait_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (rpl_pend_q)                 state_d = TX_RPL;
                else if (lk_accept || lk_act_q) state_d = SEARCH;
            end
            SEARCH:   state_d = cam_hit ? DONE : TX_REQ;
            TX_REQ:   state_d = WAIT_TXD;
            WAIT_TXD: if (tx_done) state_d = WAIT_RPL;
            WAIT_RPL: begin
                if (lk_got)              state_d = DONE;
                else if (tmr_q == '0)    state_d = (att_q < ATT_MAX) ? TX_REQ : DONE;
                else if (rpl_pend_q)     state_d = TX_RPL;
            end
            TX_RPL:   state_d = WAIT_RPLD;
            WAIT_RPLD: if (tx_done) state_d = (lk_act_q && from_wait_q) ? WAIT_RPL : IDLE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        arp_tx_en  = 1'b0;
        lookup_ack = 1'b0;
        lookup_hit = 1'b0;
        lookup_mac = '0;
        unique case (state_q)
            TX_REQ, TX_RPL: arp_tx_en = 1'b1;
            DONE: begin
                lookup_ack = 1'b1;
                lookup_hit = res_hit_q;
                lookup_mac = res_hit_q ? res_mac_q : '0;
            end
            default: ;
        endcase
    end

    assign lookup_busy = lk_act_q;
    assign arp_tx_type = tx_type_q;
    assign des_mac     = des_mac_q;
    assign des_ip      = des_ip_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_act_q    <= 1'b0;
            lk_got_q    <= 1'b0;
            lk_ip_q     <= '0;
            res_hit_q   <= 1'b0;
            res_mac_q   <= '0;
            att_q       <= '0;
            tmr_q       <= '0;
            from_wait_q <= 1'b0;
            rpl_pend_q  <= 1'b0;
            rpl_mac_q   <= '0;
            rpl_ip_q    <= '0;
            tx_type_q   <= ARP_OP_REQ;
            des_mac_q   <= '0;
            des_ip_q    <= '0;
        end else begin
            if (lk_accept)              lk_act_q <= 1'b1;
            else if (state_q == DONE)   lk_act_q <= 1'b0;

            if (lk_accept) begin
                lk_ip_q   <= lookup_ip;
                lk_got_q  <= 1'b0;
                res_hit_q <= 1'b0;
                res_mac_q <= '0;
            end else if ((state_q == SEARCH) && cam_hit) begin
                res_hit_q <= 1'b1;
                res_mac_q <= cam_mac;
            end else if (lk_act_q && rx_match && (state_q != SEARCH) && (state_q != DONE)) begin
                // Captures a reply that lands while the FSM is busy elsewhere.
                lk_got_q  <= 1'b1;
                res_hit_q <= 1'b1;
                res_mac_q <= src_mac;
            end

            if (state_q == SEARCH)                               att_q <= 4'd1;
            else if ((state_q == WAIT_RPL) && (state_d == TX_REQ)) att_q <= att_q + 4'd1;

            if ((state_q == WAIT_TXD) && tx_done) tmr_q <= TMR_LOAD;
            else if (tmr_run && (tmr_q != '0))    tmr_q <= tmr_q - 1'b1;

            if ((state_q == WAIT_RPL) && (state_d == TX_RPL)) from_wait_q <= 1'b1;
            else if ((state_q == WAIT_RPLD) && tx_done)      from_wait_q <= 1'b0;

            // A new request in the cycle the old one is taken stays pending.
            if (arp_rx_done && (arp_rx_type == ARP_OP_REQ)) begin
                rpl_pend_q <= 1'b1;
                rpl_mac_q  <= src_mac;
                rpl_ip_q   <= src_ip;
            end else if (state_d == TX_RPL) begin
                rpl_pend_q <= 1'b0;
            end

            if (state_d == TX_REQ) begin
                tx_type_q <= ARP_OP_REQ;
                des_mac_q <= ARP_BCAST_MAC;
                des_ip_q  <= lk_ip_q;
            end else if (state_d == TX_RPL) begin
                tx_type_q <= ARP_OP_RPL;
                des_mac_q <= rpl_mac_q;
                des_ip_q  <= rpl_ip_q;
            end
        end
    end

endmodule

// File: tb/tb_arp_cache_ctrl.sv
// Directed bench for arp_cache_ctrl with a tx_done responder and ack/tx monitors.
module tb_arp_cache_ctrl;
    localparam int unsigned ENTRIES     = 4;
    localparam int unsigned TIMEOUT_CYC = 100;
    localparam int unsigned RETRY_MAX   = 3;
    localparam logic [31:0] AGE_CYC     = 32'd50;

    localparam logic [47:0] BCAST = 48'hffff_ffff_ffff;
    localparam logic [31:0] IP102 = 32'hc0a8_0166;
    localparam logic [31:0] IP103 = 32'hc0a8_0167;
    localparam logic [31:0] IP104 = 32'hc0a8_0168;
    localparam logic [31:0] IP50  = 32'hc0a8_0132;
    localparam logic [47:0] MAC102 = 48'h000a_3501_fec0;

    logic        clk = 1'b0;
    logic        rst;
    logic        lookup_req, lookup_busy, lookup_ack, lookup_hit;
    logic [31:0] lookup_ip;
    logic [47:0] lookup_mac;
    logic        arp_rx_done, arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        arp_tx_en, arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic        tx_done, cache_clr;

    arp_cache_ctrl #(
        .ENTRIES(ENTRIES), .TIMEOUT_CYC(TIMEOUT_CYC), .RETRY_MAX(RETRY_MAX), .AGE_CYC(AGE_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .lookup_req(lookup_req), .lookup_ip(lookup_ip), .lookup_busy(lookup_busy),
        .lookup_ack(lookup_ack), .lookup_hit(lookup_hit), .lookup_mac(lookup_mac),
        .arp_rx_done(arp_rx_done), .arp_rx_type(arp_rx_type), .src_mac(src_mac), .src_ip(src_ip),
        .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type), .des_mac(des_mac), .des_ip(des_ip),
        .tx_done(tx_done), .cache_clr(cache_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          tx_cnt = 0, ack_cnt = 0, tx_wait = 0, ack_cyc = 0;
    int          tx_q[$];
    logic        last_type, ack_hit;
    logic [47:0] last_dmac, ack_mac;
    logic [31:0] last_dip;
    int          req_cyc, ack0, tx0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and tx_done responder (completion 3 cycles after each trigger).
    initial begin
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (lookup_ack) begin
                ack_cnt++;
                ack_hit = lookup_hit;
                ack_mac = lookup_mac;
                ack_cyc = cyc;
            end
            if (tx_done) tx_done = 1'b0;
            if (tx_wait > 0) begin
                tx_wait--;
                if (tx_wait == 0) tx_done = 1'b1;
            end
            if (arp_tx_en) begin
                chk("tx_en without prior tx_done", 64'(tx_wait != 0 || tx_done), 64'd0);
                tx_cnt++;
                tx_q.push_back(cyc);
                last_type = arp_tx_type;
                last_dmac = des_mac;
                last_dip  = des_ip;
                tx_wait   = 3;
            end
        end
    end

    task automatic rx(input logic typ, input logic [31:0] ip, input logic [47:0] mac);
        @(negedge clk);
        arp_rx_done = 1'b1; arp_rx_type = typ; src_ip = ip; src_mac = mac;
        @(negedge clk);
        arp_rx_done = 1'b0;
    endtask

    task automatic clr_pulse();
        @(negedge clk); cache_clr = 1'b1;
        @(negedge clk); cache_clr = 1'b0;
    endtask

    task automatic issue_lookup(input logic [31:0] ip);
        @(negedge clk);
        lookup_req = 1'b1; lookup_ip = ip;
        req_cyc = cyc; ack0 = ack_cnt; tx0 = tx_cnt;
        @(negedge clk);
        lookup_req = 1'b0;
    endtask

    task automatic wait_ack(input string name);
        int n = 0;
        while (ack_cnt == ack0 && n < 3000) begin @(negedge clk); n++; end
        checks++;
        if (ack_cnt == ack0) begin
            errors++;
            $display("FAIL %s: no lookup_ack within %0d cycles, expected one", name, n);
        end
    endtask

    task automatic wait_tx(input int target, input string name);
        int n = 0;
        while (tx_cnt < target && n < 1000) begin @(negedge clk); n++; end
        checks++;
        if (tx_cnt < target) begin
            errors++;
            $display("FAIL %s: tx count %0d expected %0d", name, tx_cnt, target);
        end
    endtask

    typedef struct {
        logic [31:0] ip;
        logic        exp_hit;
        logic [47:0] exp_mac;
        int          exp_req;
    } lk_vec_t;

    lk_vec_t vec[5];

    initial begin
        int s;
        // Hits first so that entries are still young in an aging build.
        vec[0] = '{ip: 32'h0a00_0002, exp_hit: 1'b1, exp_mac: 48'h0200_0000_0002, exp_req: 0};
        vec[1] = '{ip: 32'h0a00_0003, exp_hit: 1'b1, exp_mac: 48'h0200_0000_0003, exp_req: 0};
        vec[2] = '{ip: 32'h0a00_0004, exp_hit: 1'b1, exp_mac: 48'h0200_0000_0004, exp_req: 0};
        vec[3] = '{ip: 32'h0a00_0005, exp_hit: 1'b1, exp_mac: 48'h0200_0000_0005, exp_req: 0};
        vec[4] = '{ip: 32'h0a00_0001, exp_hit: 1'b0, exp_mac: 48'h0,             exp_req: 3};

        rst = 1'b1; lookup_req = 1'b0; lookup_ip = '0; arp_rx_done = 1'b0; arp_rx_type = 1'b0;
        src_mac = '0; src_ip = '0; cache_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy",   64'(lookup_busy), 64'd0);
        chk("reset ack",    64'(lookup_ack),  64'd0);
        chk("reset tx_en",  64'(arp_tx_en),   64'd0);
        chk("reset des_mac", 64'(des_mac),    64'd0);
        chk("reset des_ip", 64'(des_ip),      64'd0);
        rst = 1'b0;

        // Learned reply then hit lookup
        rx(1'b1, IP102, MAC102);
        issue_lookup(IP102);
        wait_ack("hit .102");
        chk("hit .102 latency", 64'(ack_cyc - req_cyc), 64'd2);
        chk("hit .102 hit", 64'(ack_hit), 64'd1);
        chk("hit .102 mac", 64'(ack_mac), 64'(MAC102));
        chk("hit .102 no tx", 64'(tx_cnt - tx0), 64'd0);

        // Miss with no replies: full retry sequence then fail
        clr_pulse();
        s = tx_q.size();
        issue_lookup(IP103);
        wait_ack("miss .103");
        chk("miss .103 hit", 64'(ack_hit), 64'd0);
        chk("miss .103 mac", 64'(ack_mac), 64'd0);
        chk("miss .103 requests", 64'(tx_cnt - tx0), 64'd3);
        chk("miss .103 type", 64'(last_type), 64'd0);
        chk("miss .103 des_mac", 64'(last_dmac), 64'(BCAST));
        chk("miss .103 des_ip", 64'(last_dip), 64'(IP103));
        for (int i = 1; i < 3; i++) begin
            if (tx_q.size() > s + i)
                chk($sformatf("retry gap %0d >= 100 (gap %0d)", i, tx_q[s+i] - tx_q[s+i-1]),
                    64'(tx_q[s+i] - tx_q[s+i-1] >= 100), 64'd1);
        end

        // Reply after the second request
        issue_lookup(IP103);
        wait_tx(tx0 + 2, "second request .103");
        repeat (10) @(negedge clk);
        rx(1'b1, IP103, 48'h0011_2233_4455);
        wait_ack("late reply .103");
        chk("late reply hit", 64'(ack_hit), 64'd1);
        chk("late reply mac", 64'(ack_mac), 64'h0011_2233_4455);
        chk("late reply requests", 64'(tx_cnt - tx0), 64'd2);

        // Incoming request serviced during WAIT_RPL
        issue_lookup(IP104);
        wait_tx(tx0 + 1, "request .104");
        repeat (8) @(negedge clk);
        rx(1'b0, IP50, 48'h0050_0050_0050);
        wait_tx(tx0 + 2, "reply to .50");
        chk("reply type", 64'(last_type), 64'd1);
        chk("reply des_mac", 64'(last_dmac), 64'h0050_0050_0050);
        chk("reply des_ip", 64'(last_dip), 64'(IP50));
        repeat (8) @(negedge clk);
        chk("busy during reply service", 64'(lookup_busy), 64'd1);
        rx(1'b1, IP104, 48'h0104_0104_0104);
        wait_ack("lookup .104 after reply");
        chk("lookup .104 hit", 64'(ack_hit), 64'd1);
        chk("lookup .104 mac", 64'(ack_mac), 64'h0104_0104_0104);

        // Five learns into four entries: the first is evicted
        clr_pulse();
        for (int i = 1; i <= 5; i++) rx(1'b1, 32'h0a00_0000 + 32'(i), 48'h0200_0000_0000 + 48'(i));
        for (int i = 0; i < 5; i++) begin
            issue_lookup(vec[i].ip);
            wait_ack($sformatf("vec%0d ack", i));
            chk($sformatf("vec%0d hit", i), 64'(ack_hit), 64'(vec[i].exp_hit));
            chk($sformatf("vec%0d mac", i), 64'(ack_mac), 64'(vec[i].exp_mac));
            chk($sformatf("vec%0d requests", i), 64'(tx_cnt - tx0), 64'(vec[i].exp_req));
        end

        // cache_clr invalidates a previously hitting entry
        clr_pulse();
        issue_lookup(32'h0a00_0005);
        wait_ack("after clr");
        chk("after clr hit", 64'(ack_hit), 64'd0);

        // Aging
        rx(1'b1, 32'h0a00_003c, 48'h0600_0000_003c);
        repeat (60) @(negedge clk);
        issue_lookup(32'h0a00_003c);
        wait_ack("aging lookup");
`ifdef ARP_CACHE_AGING_EN
        chk("aged entry hit", 64'(ack_hit), 64'd0);
        chk("aged entry requests", 64'(tx_cnt - tx0), 64'd3);
`else
        chk("persistent entry hit", 64'(ack_hit), 64'd1);
        chk("persistent entry mac", 64'(ack_mac), 64'h0600_0000_003c);
        chk("persistent entry requests", 64'(tx_cnt - tx0), 64'd0);
`endif

        // Learn of the searched IP in the SEARCH cycle
        @(negedge clk);
        lookup_req = 1'b1; lookup_ip = 32'h0a00_00c8;
        req_cyc = cyc; ack0 = ack_cnt; tx0 = tx_cnt;
        @(negedge clk);
        lookup_req = 1'b0;
        arp_rx_done = 1'b1; arp_rx_type = 1'b1; src_ip = 32'h0a00_00c8; src_mac = 48'h0c8c_8c8c_8c8c;
        @(negedge clk);
        arp_rx_done = 1'b0;
        wait_ack("same-cycle learn");
        chk("same-cycle latency", 64'(ack_cyc - req_cyc), 64'd2);
        chk("same-cycle hit", 64'(ack_hit), 64'd1);
        chk("same-cycle mac", 64'(ack_mac), 64'h0c8c_8c8c_8c8c);
        chk("same-cycle no tx", 64'(tx_cnt - tx0), 64'd0);

        // Reset mid-lookup abandons it
        issue_lookup(32'h0a00_0046);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset mid busy", 64'(lookup_busy), 64'd0);
        chk("reset mid des_ip", 64'(des_ip), 64'd0);
        rst = 1'b0;
        s = tx_cnt;
        repeat (400) @(negedge clk);
        chk("reset mid no ack", 64'(ack_cnt - ack0), 64'd0);
        chk("reset mid no tx", 64'(tx_cnt - s), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
